// File: rtl/uart_axil_arbiter.sv
// uart_axil_arbiter: two-master AXI4-Lite arbiter in front of the single UART
// register slave. The read and write channels are arbitrated independently.
// Each grant lasts from address acceptance through the response handshake.
// Optional build macro: UART_ARB_FIXED_PRIO_EN. When it is defined, m0 always
// wins a tie. When it is undefined (the default), ties are broken round-robin.
`timescale 1ns/1ps
module uart_axil_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // master 0
  input  logic [ADDR_W-1:0] m0_axi_awaddr,
  input  logic              m0_axi_awvalid,
  output logic              m0_axi_awready,
  input  logic [DATA_W-1:0] m0_axi_wdata,
  input  logic [3:0]        m0_axi_wstrb,
  input  logic              m0_axi_wvalid,
  output logic              m0_axi_wready,
  output logic [1:0]        m0_axi_bresp,
  output logic              m0_axi_bvalid,
  input  logic              m0_axi_bready,
  input  logic [ADDR_W-1:0] m0_axi_araddr,
  input  logic              m0_axi_arvalid,
  output logic              m0_axi_arready,
  output logic [DATA_W-1:0] m0_axi_ardata,
  output logic [1:0]        m0_axi_rresp,
  output logic              m0_axi_rvalid,
  input  logic              m0_axi_rready,
  // master 1
  input  logic [ADDR_W-1:0] m1_axi_awaddr,
  input  logic              m1_axi_awvalid,
  output logic              m1_axi_awready,
  input  logic [DATA_W-1:0] m1_axi_wdata,
  input  logic [3:0]        m1_axi_wstrb,
  input  logic              m1_axi_wvalid,
  output logic              m1_axi_wready,
  output logic [1:0]        m1_axi_bresp,
  output logic              m1_axi_bvalid,
  input  logic              m1_axi_bready,
  input  logic [ADDR_W-1:0] m1_axi_araddr,
  input  logic              m1_axi_arvalid,
  output logic              m1_axi_arready,
  output logic [DATA_W-1:0] m1_axi_ardata,
  output logic [1:0]        m1_axi_rresp,
  output logic              m1_axi_rvalid,
  input  logic              m1_axi_rready,
  // slave (UART)
  output logic [ADDR_W-1:0] s_axi_awaddr,
  output logic              s_axi_awvalid,
  input  logic              s_axi_awready,
  output logic [DATA_W-1:0] s_axi_wdata,
  output logic [3:0]        s_axi_wstrb,
  output logic              s_axi_wvalid,
  input  logic              s_axi_wready,
  input  logic [1:0]        s_axi_bresp,
  input  logic              s_axi_bvalid,
  output logic              s_axi_bready,
  output logic [ADDR_W-1:0] s_axi_araddr,
  output logic              s_axi_arvalid,
  input  logic              s_axi_arready,
  input  logic [DATA_W-1:0] s_axi_ardata,
  input  logic [1:0]        s_axi_rresp,
  input  logic              s_axi_rvalid,
  output logic              s_axi_rready,
  // current owners, one-hot, 00 = idle
  output logic [1:0]        wr_grant,
  output logic [1:0]        rd_grant
);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2} arb_state_e;

  arb_state_e wr_state_q, wr_state_d;
  arb_state_e rd_state_q, rd_state_d;
  logic       wr_pick1, rd_pick1;

`ifdef UART_ARB_FIXED_PRIO_EN
  // m1 is picked only when m0 is silent
  assign wr_pick1 = m1_axi_awvalid && !m0_axi_awvalid;
  assign rd_pick1 = m1_axi_arvalid && !m0_axi_arvalid;
`else
  // *_last_q = 1 means m1 was granted last, so m0 is preferred on a tie
  logic wr_last_q, wr_last_d;
  logic rd_last_q, rd_last_d;
  assign wr_pick1 = m1_axi_awvalid && (!m0_axi_awvalid || !wr_last_q);
  assign rd_pick1 = m1_axi_arvalid && (!m0_axi_arvalid || !rd_last_q);
`endif

  // State registers for both arbiters; asynchronous reset drops them to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= IDLE;
      rd_state_q <= IDLE;
`ifndef UART_ARB_FIXED_PRIO_EN
      wr_last_q  <= 1'b1;
      rd_last_q  <= 1'b1;
`endif
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
`ifndef UART_ARB_FIXED_PRIO_EN
      wr_last_q  <= wr_last_d;
      rd_last_q  <= rd_last_d;
`endif
    end
  end

  // Write arbiter next state: grant on AW request, release on the owner's B handshake
  always_comb begin
    wr_state_d = wr_state_q;
`ifndef UART_ARB_FIXED_PRIO_EN
    wr_last_d  = wr_last_q;
`endif
    case (wr_state_q)
      IDLE: begin
        if (m0_axi_awvalid || m1_axi_awvalid) begin
          wr_state_d = wr_pick1 ? GRANT1 : GRANT0;
`ifndef UART_ARB_FIXED_PRIO_EN
          wr_last_d  = wr_pick1;
`endif
        end
      end
      GRANT0:  if (s_axi_bvalid && m0_axi_bready) wr_state_d = IDLE;
      GRANT1:  if (s_axi_bvalid && m1_axi_bready) wr_state_d = IDLE;
      default: wr_state_d = IDLE;
    endcase
  end

  // Read arbiter next state: grant on AR request, release on the owner's R handshake
  always_comb begin
    rd_state_d = rd_state_q;
`ifndef UART_ARB_FIXED_PRIO_EN
    rd_last_d  = rd_last_q;
`endif
    case (rd_state_q)
      IDLE: begin
        if (m0_axi_arvalid || m1_axi_arvalid) begin
          rd_state_d = rd_pick1 ? GRANT1 : GRANT0;
`ifndef UART_ARB_FIXED_PRIO_EN
          rd_last_d  = rd_pick1;
`endif
        end
      end
      GRANT0:  if (s_axi_rvalid && m0_axi_rready) rd_state_d = IDLE;
      GRANT1:  if (s_axi_rvalid && m1_axi_rready) rd_state_d = IDLE;
      default: rd_state_d = IDLE;
    endcase
  end

  assign wr_grant = {wr_state_q == GRANT1, wr_state_q == GRANT0};
  assign rd_grant = {rd_state_q == GRANT1, rd_state_q == GRANT0};

  // Write path: the owner's request drives the slave, and slave replies go only to the owner
  assign s_axi_awaddr   = wr_grant[0] ? m0_axi_awaddr  : wr_grant[1] ? m1_axi_awaddr  : '0;
  assign s_axi_awvalid  = wr_grant[0] ? m0_axi_awvalid : wr_grant[1] ? m1_axi_awvalid : 1'b0;
  assign s_axi_wdata    = wr_grant[0] ? m0_axi_wdata   : wr_grant[1] ? m1_axi_wdata   : '0;
  assign s_axi_wstrb    = wr_grant[0] ? m0_axi_wstrb   : wr_grant[1] ? m1_axi_wstrb   : 4'b0;
  assign s_axi_wvalid   = wr_grant[0] ? m0_axi_wvalid  : wr_grant[1] ? m1_axi_wvalid  : 1'b0;
  assign s_axi_bready   = wr_grant[0] ? m0_axi_bready  : wr_grant[1] ? m1_axi_bready  : 1'b0;
  assign m0_axi_awready = wr_grant[0] & s_axi_awready;
  assign m1_axi_awready = wr_grant[1] & s_axi_awready;
  assign m0_axi_wready  = wr_grant[0] & s_axi_wready;
  assign m1_axi_wready  = wr_grant[1] & s_axi_wready;
  assign m0_axi_bvalid  = wr_grant[0] & s_axi_bvalid;
  assign m1_axi_bvalid  = wr_grant[1] & s_axi_bvalid;
  assign m0_axi_bresp   = wr_grant[0] ? s_axi_bresp : 2'b00;
  assign m1_axi_bresp   = wr_grant[1] ? s_axi_bresp : 2'b00;

  // Read path: same ownership steering as the write path
  assign s_axi_araddr   = rd_grant[0] ? m0_axi_araddr  : rd_grant[1] ? m1_axi_araddr  : '0;
  assign s_axi_arvalid  = rd_grant[0] ? m0_axi_arvalid : rd_grant[1] ? m1_axi_arvalid : 1'b0;
  assign s_axi_rready   = rd_grant[0] ? m0_axi_rready  : rd_grant[1] ? m1_axi_rready  : 1'b0;
  assign m0_axi_arready = rd_grant[0] & s_axi_arready;
  assign m1_axi_arready = rd_grant[1] & s_axi_arready;
  assign m0_axi_rvalid  = rd_grant[0] & s_axi_rvalid;
  assign m1_axi_rvalid  = rd_grant[1] & s_axi_rvalid;
  assign m0_axi_ardata  = rd_grant[0] ? s_axi_ardata : '0;
  assign m1_axi_ardata  = rd_grant[1] ? s_axi_ardata : '0;
  assign m0_axi_rresp   = rd_grant[0] ? s_axi_rresp : 2'b00;
  assign m1_axi_rresp   = rd_grant[1] ? s_axi_rresp : 2'b00;

endmodule

// File: tb/tb_uart_axil_arbiter.sv
// Directed bench for uart_axil_arbiter, with a small behavioural UART slave.
// The slave returns SLVERR for addresses above 0x04, so the bench can see
// that responses are forwarded unchanged.
`timescale 1ns/1ps
module tb_uart_axil_arbiter;

  localparam logic [31:0] STATUS_WORD = 32'h0000_0005;
  localparam logic [31:0] RX_WORD     = 32'h0000_005A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // master-side signals, index = master number
  logic [31:0] m_awaddr [2];
  logic        m_awvalid[2];
  logic        m_awready[2];
  logic [31:0] m_wdata  [2];
  logic [3:0]  m_wstrb  [2];
  logic        m_wvalid [2];
  logic        m_wready [2];
  logic [1:0]  m_bresp  [2];
  logic        m_bvalid [2];
  logic        m_bready [2];
  logic [31:0] m_araddr [2];
  logic        m_arvalid[2];
  logic        m_arready[2];
  logic [31:0] m_ardata [2];
  logic [1:0]  m_rresp  [2];
  logic        m_rvalid [2];
  logic        m_rready [2];

  logic [31:0] s_awaddr, s_wdata, s_araddr, s_ardata;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]  s_bresp, s_rresp;
  logic [1:0]  wr_grant, rd_grant;

  uart_axil_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_axi_awaddr(m_awaddr[0]), .m0_axi_awvalid(m_awvalid[0]), .m0_axi_awready(m_awready[0]),
    .m0_axi_wdata(m_wdata[0]), .m0_axi_wstrb(m_wstrb[0]), .m0_axi_wvalid(m_wvalid[0]), .m0_axi_wready(m_wready[0]),
    .m0_axi_bresp(m_bresp[0]), .m0_axi_bvalid(m_bvalid[0]), .m0_axi_bready(m_bready[0]),
    .m0_axi_araddr(m_araddr[0]), .m0_axi_arvalid(m_arvalid[0]), .m0_axi_arready(m_arready[0]),
    .m0_axi_ardata(m_ardata[0]), .m0_axi_rresp(m_rresp[0]), .m0_axi_rvalid(m_rvalid[0]), .m0_axi_rready(m_rready[0]),
    .m1_axi_awaddr(m_awaddr[1]), .m1_axi_awvalid(m_awvalid[1]), .m1_axi_awready(m_awready[1]),
    .m1_axi_wdata(m_wdata[1]), .m1_axi_wstrb(m_wstrb[1]), .m1_axi_wvalid(m_wvalid[1]), .m1_axi_wready(m_wready[1]),
    .m1_axi_bresp(m_bresp[1]), .m1_axi_bvalid(m_bvalid[1]), .m1_axi_bready(m_bready[1]),
    .m1_axi_araddr(m_araddr[1]), .m1_axi_arvalid(m_arvalid[1]), .m1_axi_arready(m_arready[1]),
    .m1_axi_ardata(m_ardata[1]), .m1_axi_rresp(m_rresp[1]), .m1_axi_rvalid(m_rvalid[1]), .m1_axi_rready(m_rready[1]),
    .s_axi_awaddr(s_awaddr), .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready),
    .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb), .s_axi_wvalid(s_wvalid), .s_axi_wready(s_wready),
    .s_axi_bresp(s_bresp), .s_axi_bvalid(s_bvalid), .s_axi_bready(s_bready),
    .s_axi_araddr(s_araddr), .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready),
    .s_axi_ardata(s_ardata), .s_axi_rresp(s_rresp), .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
    .wr_grant(wr_grant), .rd_grant(rd_grant)
  );

  // Behavioural UART slave: AW and W are accepted together, B follows next cycle; R follows AR by one cycle
  logic        sl_bvalid_q, sl_rvalid_q;
  logic [1:0]  sl_bresp_q, sl_rresp_q;
  logic [31:0] sl_rdata_q, sl_last_wdata_q;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sl_bvalid_q <= 1'b0; sl_rvalid_q <= 1'b0; sl_bresp_q <= 2'b00; sl_rresp_q <= 2'b00;
      sl_rdata_q <= '0; sl_last_wdata_q <= '0;
    end else begin
      if (s_awvalid && s_wvalid && !sl_bvalid_q) begin
        sl_bvalid_q     <= 1'b1;
        sl_bresp_q      <= (s_awaddr > 32'h4) ? 2'b10 : 2'b00;
        sl_last_wdata_q <= s_wdata;
      end else if (sl_bvalid_q && s_bready) begin
        sl_bvalid_q <= 1'b0;
      end
      if (s_arvalid && !sl_rvalid_q) begin
        sl_rvalid_q <= 1'b1;
        sl_rresp_q  <= (s_araddr > 32'h4) ? 2'b10 : 2'b00;
        sl_rdata_q  <= (s_araddr == 32'h4) ? STATUS_WORD : RX_WORD;
      end else if (sl_rvalid_q && s_rready) begin
        sl_rvalid_q <= 1'b0;
      end
    end
  end
  assign s_awready = s_awvalid && s_wvalid && !sl_bvalid_q;
  assign s_wready  = s_awready;
  assign s_bvalid  = sl_bvalid_q;
  assign s_bresp   = sl_bresp_q;
  assign s_arready = s_arvalid && !sl_rvalid_q;
  assign s_rvalid  = sl_rvalid_q;
  assign s_rresp   = sl_rresp_q;
  assign s_ardata  = sl_rdata_q;

  // OR of every DUT output, and of master 1's outputs alone
  logic m1_any, out_any;
  assign m1_any  = |{m_awready[1], m_wready[1], m_bresp[1], m_bvalid[1], m_arready[1], m_ardata[1], m_rresp[1], m_rvalid[1]};
  assign out_any = m1_any | (|{m_awready[0], m_wready[0], m_bresp[0], m_bvalid[0], m_arready[0], m_ardata[0],
                               m_rresp[0], m_rvalid[0], s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
                               s_araddr, s_arvalid, s_rready, wr_grant, rd_grant});

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One write from master m; reports response, first granted cycle and B handshake cycle
  task automatic mwrite(input int m, input logic [31:0] a, input logic [31:0] d,
                        output logic [1:0] resp, output int gcyc, output int dcyc);
    logic aw_hs, b_hs;
    m_awaddr[m] = a; m_wdata[m] = d; m_wstrb[m] = 4'hF;
    m_awvalid[m] = 1'b1; m_wvalid[m] = 1'b1; m_bready[m] = 1'b1;
    gcyc = -1; dcyc = -1; resp = 2'bxx;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (gcyc < 0 && wr_grant[m]) gcyc = cyc;
      aw_hs = m_awvalid[m] && m_awready[m];
      b_hs  = m_bvalid[m] && m_bready[m];
      if (b_hs) begin resp = m_bresp[m]; dcyc = cyc; end
      @(posedge clk); #1;
      if (aw_hs) begin m_awvalid[m] = 1'b0; m_wvalid[m] = 1'b0; end
      if (b_hs) begin m_bready[m] = 1'b0; break; end
    end
    check_vec($sformatf("wr_m%0d_done", m), dcyc >= 0, 1);
    $display("write m%0d addr=%0h data=%0h resp=%0d grant@%0d done@%0d", m, a, d, resp, gcyc, dcyc);
  endtask

  // One read from master m; rready is held low for dly cycles after AR is accepted
  task automatic mread(input int m, input logic [31:0] a, input int dly, output logic [31:0] data,
                       output logic [1:0] resp, output int gcyc, output int dcyc);
    logic ar_hs, r_hs, ar_done;
    int n;
    m_araddr[m] = a; m_arvalid[m] = 1'b1; m_rready[m] = (dly == 0);
    gcyc = -1; dcyc = -1; ar_done = 1'b0; n = 0; data = 'x; resp = 2'bxx;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (gcyc < 0 && rd_grant[m]) gcyc = cyc;
      ar_hs = m_arvalid[m] && m_arready[m];
      r_hs  = m_rvalid[m] && m_rready[m];
      if (r_hs) begin data = m_ardata[m]; resp = m_rresp[m]; dcyc = cyc; end
      @(posedge clk); #1;
      if (ar_hs) begin m_arvalid[m] = 1'b0; ar_done = 1'b1; end
      if (r_hs) begin m_rready[m] = 1'b0; break; end
      if (ar_done && !ar_hs && !m_rready[m]) begin
        if (n >= dly) m_rready[m] = 1'b1;
        n++;
      end
    end
    check_vec($sformatf("rd_m%0d_done", m), dcyc >= 0, 1);
    $display("read  m%0d addr=%0h data=%0h resp=%0d grant@%0d done@%0d", m, a, data, resp, gcyc, dcyc);
  endtask

  // Both masters write in the same cycle; exp_first is the master expected to win
  task automatic tie_write(input string tag, input int exp_first);
    logic [1:0] r0, r1, g;
    int g0, g1, d0, d1;
    fork
      mwrite(0, 32'h0, 32'h55, r0, g0, d0);
      mwrite(1, 32'h0, 32'hAA, r1, g1, d1);
      begin @(negedge clk); @(negedge clk); g = wr_grant; end
    join
    check_vec({tag, "_grant"}, g, (exp_first == 0) ? 2'b01 : 2'b10);
    check_vec({tag, "_order"}, (d0 < d1) ? 0 : 1, exp_first);
    check_vec({tag, "_lastdata"}, sl_last_wdata_q, (exp_first == 0) ? 32'hAA : 32'h55);
    check_vec({tag, "_bresp"}, {r0, r1}, 4'b0000);
  endtask

  logic [1:0]  resp_a, resp_b;
  logic [31:0] data_a, data_b;
  int ga, da, gb, db;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_awaddr[i] = '0; m_awvalid[i] = 1'b0; m_wdata[i] = '0; m_wstrb[i] = 4'h0; m_wvalid[i] = 1'b0;
      m_bready[i] = 1'b0; m_araddr[i] = '0; m_arvalid[i] = 1'b0; m_rready[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_vec("reset_outputs", out_any, 0);
    check_vec("reset_grants", {wr_grant, rd_grant}, 4'b0000);
    @(posedge clk); #1 rst = 1'b0;

    // first two ties after reset both go to m0
    tie_write("tie1", 0);
    tie_write("tie2", 0);

    // single write from m0, checked cycle by cycle
    m_awaddr[0] = 32'h0; m_wdata[0] = 32'h41; m_wstrb[0] = 4'hF;
    m_awvalid[0] = 1'b1; m_wvalid[0] = 1'b1; m_bready[0] = 1'b1;
    @(negedge clk);
    check_vec("w1_idle_grant", wr_grant, 2'b00);
    check_vec("w1_idle_awvalid", s_awvalid, 0);
    @(negedge clk);
    check_vec("w1_grant", wr_grant, 2'b01);
    check_vec("w1_s_wdata", s_wdata, 32'h41);
    check_vec("w1_s_awvalid", s_awvalid, 1);
    check_vec("w1_m0_awready", m_awready[0], 1);
    check_vec("w1_m1_quiet_a", m1_any, 0);
    @(posedge clk); #1 m_awvalid[0] = 1'b0; m_wvalid[0] = 1'b0;
    @(negedge clk);
    check_vec("w1_m0_bvalid", m_bvalid[0], 1);
    check_vec("w1_m0_bresp", m_bresp[0], 2'b00);
    check_vec("w1_m1_quiet_b", m1_any, 0);
    @(negedge clk);
    check_vec("w1_release", wr_grant, 2'b00);
    check_vec("w1_m0_bvalid_off", m_bvalid[0], 0);
    @(posedge clk); #1 m_bready[0] = 1'b0;
    $display("write m0 addr=0 data=41 (stepped)");

    // m0 was granted last, so round-robin favours m1 here; fixed priority still picks m0
`ifdef UART_ARB_FIXED_PRIO_EN
    tie_write("tie3", 0);
`else
    tie_write("tie3", 1);
`endif

    // concurrent write (m0) and status read (m1)
    fork
      mwrite(0, 32'h0, 32'h33, resp_a, ga, da);
      mread(1, 32'h4, 0, data_b, resp_b, gb, db);
      begin
        @(negedge clk); @(negedge clk);
        check_vec("rw_grants", {wr_grant, rd_grant}, 4'b0110);
      end
    join
    check_vec("rw_status", data_b, STATUS_WORD);
    check_vec("rw_rresp", resp_b, 2'b00);
    check_vec("rw_bresp", resp_a, 2'b00);

    // m0 stalls rready while m1 holds arvalid
    fork
      mread(0, 32'h0, 5, data_a, resp_a, ga, da);
      begin @(posedge clk); #1 mread(1, 32'h4, 0, data_b, resp_b, gb, db); end
      begin
        @(negedge clk); @(negedge clk);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check_vec($sformatf("hold_rd_grant_%0d", i), rd_grant, 2'b01);
          check_vec($sformatf("hold_m1_arready_%0d", i), m_arready[1], 0);
          check_vec($sformatf("hold_m1_quiet_%0d", i), {m_rvalid[1], m_ardata[1]}, 0);
        end
      end
    join
    check_vec("hold_m0_data", data_a, RX_WORD);
    check_vec("hold_m1_data", data_b, STATUS_WORD);
    check_vec("hold_m1_grant_cycle", gb, da + 2);

    // error response is forwarded unchanged
    mwrite(1, 32'h8, 32'h99, resp_a, ga, da);
    check_vec("slverr_bresp", resp_a, 2'b10);
    mread(0, 32'h8, 0, data_a, resp_a, ga, da);
    check_vec("slverr_rresp", resp_a, 2'b10);

    // reset while m1 holds the write channel with B pending
    m_awaddr[1] = 32'h0; m_wdata[1] = 32'h77; m_wstrb[1] = 4'hF;
    m_awvalid[1] = 1'b1; m_wvalid[1] = 1'b1; m_bready[1] = 1'b0;
    @(negedge clk); @(negedge clk);
    check_vec("rst_pre_grant", wr_grant, 2'b10);
    @(posedge clk); #1 m_awvalid[1] = 1'b0; m_wvalid[1] = 1'b0;
    @(negedge clk);
    check_vec("rst_pre_bvalid", m_bvalid[1], 1);
    #1 rst = 1'b1;
    #1 check_vec("rst_mid_outputs", out_any, 0);
    check_vec("rst_mid_grant", wr_grant, 2'b00);
    $display("reset asserted mid-write at cycle %0d", cyc);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    tie_write("tie_after_rst", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/uart_axil_arbiter.md
# uart_axil_arbiter

Two-master AXI4-Lite arbiter that shares the single UART register slave (TX/RX data at 0x00, status at 0x04) between two requesters, for example the CPU data port and a debug/DMA master. Read and write channels are arbitrated independently. Each grant is held for one complete transaction, from address through response. The block sits between the interconnect masters and the UART's axi_* slave port; the slave side connects directly to it.

## Interface
Parameters:
- ADDR_W, 32, address width carried on AW/AR.
- DATA_W, 32, data width carried on W/R.

Ports (the m0_/m1_ prefixes share directions and widths):
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- m{0,1}_axi_awaddr  in  ADDR_W; m{0,1}_axi_awvalid  in  1; m{0,1}_axi_awready  out  1  write address channel per master.
- m{0,1}_axi_wdata  in  DATA_W; m{0,1}_axi_wstrb  in  4; m{0,1}_axi_wvalid  in  1; m{0,1}_axi_wready  out  1  write data channel.
- m{0,1}_axi_bresp  out  2; m{0,1}_axi_bvalid  out  1; m{0,1}_axi_bready  in  1  write response channel.
- m{0,1}_axi_araddr  in  ADDR_W; m{0,1}_axi_arvalid  in  1; m{0,1}_axi_arready  out  1  read address channel.
- m{0,1}_axi_ardata  out  DATA_W; m{0,1}_axi_rresp  out  2; m{0,1}_axi_rvalid  out  1; m{0,1}_axi_rready  in  1  read data channel.
- s_axi_*  (mirror of the above, opposite directions)  the single slave port, wired to the UART axi_* ports.
- wr_grant  out  2  one-hot current write owner; 00 means idle.
- rd_grant  out  2  one-hot current read owner; 00 means idle.

## Operation
The write arbiter and read arbiter are identical state machines.

States:
- IDLE: no owner.
- GRANT0: m0 owns the channel.
- GRANT1: m1 owns the channel.

Transitions:
- In IDLE, with a request pending (awvalid for write, arvalid for read), the arbiter moves to GRANTn on the next clock.
- If only one master requests, it wins.
- If both request, the master other than the last-granted master wins (round robin). The last-granted pointer resets to 1, so m0 wins the first tie.
- GRANTn returns to IDLE on the cycle the owner's response handshake completes: s_axi_bvalid && mN_bready for write, s_axi_rvalid && mN_rready for read.
- The last-granted pointer updates on grant entry.

Datapath while in GRANTn (combinational):
- The owner's request signals (addr, wdata, wstrb, valid) drive s_axi_*.
- Slave readies and responses (awready, wready, bvalid, bresp, ardata, rvalid, rresp) route only to the owner.
- The non-owner sees ready = 0 and valid = 0, with data/resp outputs forced to 0.

Datapath in IDLE:
- All s_axi_* request outputs are 0.
- All master-side readies, valids and data outputs are 0.

Other rules:
- A requester that loses arbitration must hold its valid; the arbiter never drops a pending request.
- The arbiter does not inspect addresses. It forwards the slave's bresp/rresp unchanged.
- Reset mid-transaction: both FSMs go to IDLE and all outputs go to 0 immediately (asynchronous). The slave must be reset on the same rst edge.

## Timing
- Reset values: wr_grant = rd_grant = 00, and every output = 0. This includes all readies and valids on both sides.
- Grant latency is 1 cycle: a valid first seen in IDLE reaches s_axi_*valid on the next clock, then passes through with zero added latency.
- Back-to-back transactions need a minimum of 1 IDLE cycle between grants on the same channel, because IDLE is always entered after a response.
- Read and write grants may belong to different masters at the same time.
- A response handshake and a new request in the same cycle: the FSM goes to IDLE first, and the new request is arbitrated on the following cycle.

## Configuration
- UART_ARB_FIXED_PRIO_EN defined: fixed priority, where m0 always wins when both masters request. The last-granted pointer is not implemented, and m1 is served only when m0 is not requesting in IDLE.
- Not defined: round-robin as described above.

## Test plan
- Single write: m0 writes 0x41 to 0x00 -> wr_grant = 01 one cycle after awvalid; s_axi_wdata = 0x41; m0_bvalid asserted with bresp = 00; then wr_grant = 00. m1 outputs stay 0 throughout.
- Simultaneous writes: m0 writes 0x55 and m1 writes 0xAA in the same cycle -> m0 is served first, then m1 (round robin). A second tie is then won by m0 again, since m1 was last granted. Under UART_ARB_FIXED_PRIO_EN, m0 wins both ties.
- Concurrent read and write: m1 reads 0x04 while m0 writes 0x00 -> rd_grant = 10 and wr_grant = 01 at the same time. m1_ardata = the UART status word, and m0 receives bvalid.
- Held request under contention: m1 holds arvalid while m0 stalls rready low for 5 cycles -> rd_grant stays 01 and m1_arready stays 0. m1 is granted in the cycle after m0's R handshake plus one IDLE cycle.
- Reset mid-transaction: assert rst while wr_grant = 10 and before B completes -> all outputs are 0 in the same cycle. After rst deasserts, the first tie goes to m0.
